// File: rtl/div_pkg.sv
// Shared state type and counter sizing helper for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Width of a down-counter that must hold iterations-1.
  function automatic int cnt_width(input int iterations);
    return (iterations <= 2) ? 1 : $clog2(iterations);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract, restore if negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH_D = 16
) (
  input  logic [WIDTH_D:0]   i_rem,
  input  logic               i_n_bit,
  input  logic [WIDTH_D-1:0] i_d,
  output logic [WIDTH_D:0]   o_rem,
  output logic               o_q_bit
);

  logic [WIDTH_D+1:0] w_shift;
  logic [WIDTH_D:0]   w_trial;

  assign w_shift = {i_rem, i_n_bit};
  assign w_trial = w_shift[WIDTH_D:0] - {1'b0, i_d};
  // The compare uses the full shifted value so a zero divisor still yields a 1 quotient bit.
  assign o_q_bit = (w_shift >= {2'b00, i_d});
  assign o_rem   = o_q_bit ? w_trial : w_shift[WIDTH_D:0];

endmodule

// File: rtl/divider_seq.sv
// Sequential radix-2 restoring divider, valid/ready on both sides, one operation in flight.
// Optional div_by_zero output is built only when DIVIDER_DBZ_FLAG_EN is defined.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | WIDTH_N restoring iterations, one quotient bit per edge, MSB first
// DONE  | result presented, waiting for out_ready
module divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 16,
  parameter int SIGNED  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] N,
  input  logic [WIDTH_D-1:0] D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] Q,
  output logic [WIDTH_D-1:0] R
`ifdef DIVIDER_DBZ_FLAG_EN
  ,
  output logic               div_by_zero
`endif
);

  localparam int CW = cnt_width(WIDTH_N);

  div_state_t         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH_N-1:0] r_n;
  logic [WIDTH_D-1:0] r_d;
  logic [WIDTH_D:0]   r_rem;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_out_valid;
  logic [WIDTH_N-1:0] r_q;
  logic [WIDTH_D-1:0] r_r;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic               r_dbz;
`endif

  logic               w_n_neg;
  logic               w_d_neg;
  logic [WIDTH_N-1:0] w_n_abs;
  logic [WIDTH_D-1:0] w_d_abs;
  logic [WIDTH_D:0]   w_rem_next;
  logic               w_q_bit;
  logic [WIDTH_N-1:0] w_q_mag;
  logic [WIDTH_D-1:0] w_r_mag;
  logic               w_d_zero;

  assign w_n_neg  = (SIGNED != 0) && N[WIDTH_N-1];
  assign w_d_neg  = (SIGNED != 0) && D[WIDTH_D-1];
  assign w_n_abs  = w_n_neg ? -N : N;
  assign w_d_abs  = w_d_neg ? -D : D;
  assign w_q_mag  = {r_n[WIDTH_N-2:0], w_q_bit};
  assign w_r_mag  = w_rem_next[WIDTH_D-1:0];
  assign w_d_zero = (r_d == '0);

  // r_n doubles as dividend shifter (top bit out) and quotient accumulator (bottom bit in).
  div_step #(.WIDTH_D(WIDTH_D)) u_step (
    .i_rem   (r_rem),
    .i_n_bit (r_n[WIDTH_N-1]),
    .i_d     (r_d),
    .o_rem   (w_rem_next),
    .o_q_bit (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_n         <= '0;
      r_d         <= '0;
      r_rem       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
`ifdef DIVIDER_DBZ_FLAG_EN
      r_dbz       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_n      <= w_n_abs;
            r_d      <= w_d_abs;
            r_rem    <= '0;
            r_sign_q <= w_n_neg ^ w_d_neg;
            r_sign_r <= w_n_neg;
            r_cnt    <= CW'(WIDTH_N - 1);
`ifdef DIVIDER_DBZ_FLAG_EN
            r_dbz    <= (D == '0);
`endif
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_n   <= w_q_mag;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            // Zero divisor keeps the all-ones quotient regardless of operand signs.
            r_q         <= w_d_zero ? '1 : (r_sign_q ? -w_q_mag : w_q_mag);
            r_r         <= r_sign_r ? -w_r_mag : w_r_mag;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign Q         = r_q;
  assign R         = r_r;
`ifdef DIVIDER_DBZ_FLAG_EN
  assign div_by_zero = r_dbz;
`endif

endmodule
